// File: rtl/motor_pkg.sv
// motor_pkg: command frame layout and quadrature phase encoding shared by the encoder emulator
package motor_pkg;
  localparam int FRAME_W = 12;
  localparam int DIR_BIT = 11;
  localparam int EN_BIT = 10;
  localparam int CODE_W = 10;
  localparam logic [1:0] QUAD_0 = 2'b00;
  localparam logic [1:0] QUAD_1 = 2'b10;
  localparam logic [1:0] QUAD_2 = 2'b11;
  localparam logic [1:0] QUAD_3 = 2'b01;
  typedef struct packed {
    logic dir;
    logic en;
    logic [CODE_W-1:0] code;
  } cmd_t;
  function automatic logic [1:0] quad_ab(input logic [1:0] ph);
    return ph == 2'd0 ? QUAD_0 : ph == 2'd1 ? QUAD_1 : ph == 2'd2 ? QUAD_2 : QUAD_3;
  endfunction
endpackage

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: synchronizes scl/sdi and assembles 12-bit MSB-first command frames
module serial_frame_rx
  import motor_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               scl,
  input  logic               sdi,
  output logic [FRAME_W-1:0] frame,
  output logic               done
);
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [1:0] scl_sync_q, scl_sync_d, sdi_sync_q, sdi_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic rise, expire;
  // Edge detect, shifting, frame completion and expiry of a stalled partial frame
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sdi_sync_d = {sdi_sync_q[0], sdi};
    scl_prev_d = scl_sync_q[1];
    rise = scl_sync_q[1] & ~scl_prev_q;
    frame = {shift_q[FRAME_W-2:0], sdi_sync_q[1]};
    done = rise && bit_cnt_q == 4'(FRAME_W - 1);
    expire = !rise && bit_cnt_q != '0 && idle_q == IW'(TIMEOUT - 1);
    shift_d = rise ? frame : shift_q;
    bit_cnt_d = (done || expire) ? '0 : rise ? bit_cnt_q + 4'd1 : bit_cnt_q;
    idle_d = (rise || expire || bit_cnt_q == '0) ? '0 : idle_q + IW'(1);
  end
  // Receiver state registers
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      scl_sync_q <= '0;
      sdi_sync_q <= '0;
      scl_prev_q <= 1'b0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      idle_q <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sdi_sync_q <= sdi_sync_d;
      scl_prev_q <= scl_prev_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q <= idle_d;
    end
endmodule

// File: rtl/quad_encoder_emu.sv
// quad_encoder_emu: serial-commanded quadrature A/B/index generator
module quad_encoder_emu
  import motor_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int COUNTS_PER_REV = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sdi,
  output logic a,
  output logic b,
  output logic idx,
  output logic cmd_valid
);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam int SW = $clog2(COUNTS_PER_REV);
  localparam logic [SW-1:0] LAST = SW'(COUNTS_PER_REV - 1);
  logic [1:0] rst_sync_q, rst_sync_d;
  logic rst_n, done, tick, wrap, step;
  logic [FRAME_W-1:0] frame;
  cmd_t cmd_q, cmd_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CODE_W-1:0] stp_q, stp_d;
  logic [SW-1:0] pos_q, pos_d;
  logic [1:0] ab_q, ab_d;
  logic idx_q, idx_d, cmd_valid_q, cmd_valid_d;
  // Reset release shifts in ones so deassertion lands on a clock edge
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  // Reset synchronizer: clears immediately, releases after two clocks
  always_ff @(posedge clock or negedge reset)
    if (!reset) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;
  assign rst_n = rst_sync_q[1];
  serial_frame_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clock(clock),
    .rst_n(rst_n),
    .scl(scl),
    .sdi(sdi),
    .frame(frame),
    .done(done)
  );
  // Rate generator and position update; a commit restarts the interval and swallows a coincident step
  always_comb begin
    tick = cmd_q.en && pre_q == PW'(PRESCALE - 1);
    wrap = tick && stp_q == cmd_q.code;
    step = wrap && !done;
    cmd_d = done ? cmd_t'(frame) : cmd_q;
    pre_d = (done || !cmd_q.en || tick) ? '0 : pre_q + PW'(1);
    stp_d = (done || !cmd_q.en || wrap) ? '0 : tick ? stp_q + CODE_W'(1) : stp_q;
    pos_d = !step ? pos_q
          : cmd_q.dir ? (pos_q == LAST ? '0 : pos_q + SW'(1))
          : (pos_q == '0 ? LAST : pos_q - SW'(1));
    ab_d = quad_ab(pos_d[1:0]);
    idx_d = pos_d == '0;
    cmd_valid_d = done;
  end
  // Command, counters, position and glitch-free registered outputs
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      cmd_q <= '0;
      pre_q <= '0;
      stp_q <= '0;
      pos_q <= '0;
      ab_q <= QUAD_0;
      idx_q <= 1'b1;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      pre_q <= pre_d;
      stp_q <= stp_d;
      pos_q <= pos_d;
      ab_q <= ab_d;
      idx_q <= idx_d;
      cmd_valid_q <= cmd_valid_d;
    end
  assign a = ab_q[1];
  assign b = ab_q[0];
  assign idx = idx_q;
  assign cmd_valid = cmd_valid_q;
endmodule

// File: tb/tb_quad_encoder_emu.sv
// tb_quad_encoder_emu: directed checks of framing, stepping, wrap, reversal, timeout and reset
module tb_quad_encoder_emu;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic scl = 1'b0;
  logic sdi = 1'b0;
  logic a, b, idx, cmd_valid;
  int n_checks = 0;
  int n_err = 0;
  int cv_count = 0;
  logic pa = 1'b0;
  logic pb = 1'b0;
  bit mon_ok = 1'b0;
  localparam logic [11:0] F1 = 12'hC04;
  localparam logic [11:0] F2 = 12'h404;
  localparam logic [11:0] F3 = 12'h404;
  localparam logic [11:0] F4 = 12'h400;
  localparam logic [11:0] F5 = 12'hC00;
  localparam logic [11:0] F6 = 12'h809;
  localparam logic [11:0] F7 = 12'hC00;
  localparam logic [11:0] F8 = 12'hC02;

  quad_encoder_emu dut (
    .clock(clock),
    .reset(reset),
    .scl(scl),
    .sdi(sdi),
    .a(a),
    .b(b),
    .idx(idx),
    .cmd_valid(cmd_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && cmd_valid) cv_count++;
    if (reset && mon_ok) begin
      n_checks++;
      assert (!(a !== pa && b !== pb))
      else begin
        n_err++;
        $error("FAIL glitch: observed ab=%b%b after %b%b, required one channel change at most", a, b, pa, pb);
      end
    end
    mon_ok = reset;
    pa = a;
    pb = b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_head(input logic [11:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = f[11-i];
      scl = 1'b0;
      clk_n(2);
      scl = 1'b1;
      clk_n(2);
    end
    scl = 1'b0;
  endtask

  task automatic commit(input string tag, input logic [11:0] f);
    sdi = f[0];
    scl = 1'b0;
    clk_n(2);
    scl = 1'b1;
    clk_n(3);
    chk({tag, "_cv"}, cmd_valid, 1);
    clk_n(1);
    chk({tag, "_cv_once"}, cmd_valid, 0);
    scl = 1'b0;
  endtask

  initial begin
    clk_n(3);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_idx", idx, 1);
    chk("rst_cv", cmd_valid, 0);
    reset = 1'b1;
    clk_n(4);
    send_head(F1, 11);
    commit("f1", F1);
    clk_n(48); chk("f1_hold", {a, b}, 2'b00);
    clk_n(1);  chk("f1_s1", {a, b}, 2'b10); chk("f1_idx", idx, 0);
    clk_n(50); chk("f1_s2", {a, b}, 2'b11);
    clk_n(50); chk("f1_s3", {a, b}, 2'b01);
    clk_n(50); chk("f1_s4", {a, b}, 2'b00); chk("f1_idx4", idx, 0);
    send_head(F2, 11);
    clk_n(6);  chk("f1_s5", {a, b}, 2'b10);
    clk_n(50); chk("f1_s6", {a, b}, 2'b11);
    commit("rev", F2);
    clk_n(48); chk("rev_hold", {a, b}, 2'b11);
    clk_n(1);  chk("rev_s1", {a, b}, 2'b10);
    send_head(F3, 11);
    clk_n(1);
    commit("coinc", F3);
    chk("coinc_suppressed", {a, b}, 2'b10);
    clk_n(48); chk("coinc_hold", {a, b}, 2'b10);
    clk_n(1);  chk("coinc_s1", {a, b}, 2'b00);
    send_head(F4, 11);
    commit("bwd", F4);
    clk_n(38); chk("bwd_pos1", {a, b}, 2'b10); chk("bwd_idx_lo", idx, 0);
    clk_n(1);  chk("bwd_pos0", {a, b}, 2'b00); chk("bwd_idx_hi", idx, 1);
    clk_n(9);  chk("bwd_idx_hold", idx, 1);
    clk_n(1);  chk("bwd_wrap", {a, b}, 2'b01); chk("bwd_idx_fall", idx, 0);
    send_head(F5, 11);
    commit("fwd", F5);
    chk("fwd_pos1019", {a, b}, 2'b01);
    clk_n(48); chk("fwd_pos1023", {a, b}, 2'b01); chk("fwd_idx_lo", idx, 0);
    clk_n(1);  chk("fwd_wrap", {a, b}, 2'b00); chk("fwd_idx_hi", idx, 1);
    clk_n(9);  chk("fwd_idx_hold", idx, 1);
    clk_n(1);  chk("fwd_pos1", {a, b}, 2'b10); chk("fwd_idx_fall", idx, 0);
    send_head(F1, 7);
    clk_n(4106);
    chk("to_idle_cv", cv_count, 5);
    send_head(F6, 11);
    chk("to_head_cv", cv_count, 5);
    commit("to", F6);
    chk("to_pos419", {a, b}, 2'b01);
    clk_n(200);
    chk("to_frozen", {a, b}, 2'b01);
    chk("to_frozen_idx", idx, 0);
    send_head(F7, 11);
    commit("run", F7);
    clk_n(25); chk("run_pos421", {a, b}, 2'b10);
    send_head(F8, 5);
    reset = 1'b0;
    #1;
    chk("mid_rst_a", a, 0);
    chk("mid_rst_b", b, 0);
    chk("mid_rst_idx", idx, 1);
    chk("mid_rst_cv", cmd_valid, 0);
    clk_n(2);
    reset = 1'b1;
    clk_n(4);
    send_head(F8, 11);
    commit("post", F8);
    clk_n(28); chk("post_hold", {a, b}, 2'b00); chk("post_idx", idx, 1);
    clk_n(1);  chk("post_s1", {a, b}, 2'b10); chk("post_idx_fall", idx, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/quad_encoder_emu.md
# quad_encoder_emu

Quadrature encoder emulator: the transmit-side counterpart of the motor-control chip's quadrature decoders. It takes a serial speed/direction command from the microcontroller, clocked in on the shared SCL line, and produces A/B quadrature waves plus a once-per-revolution index pulse. It is used to drive the decoder inputs in closed-loop bring-up and as a standalone encoder simulator on the same chip.

## Interface
Parameters:
- `PRESCALE`, 10: clock cycles per rate tick (1 µs at 10 MHz).
- `COUNTS_PER_REV`, 1024: quadrature steps per revolution. Must be a multiple of 4 and at least 4.
- `TIMEOUT`, 4096: idle clock cycles after which a partial serial frame is discarded.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `scl`, in, 1: serial clock from the MCU. Asynchronous to `clock`.
- `sdi`, in, 1: serial data, sampled on `scl` rising edges.
- `a`, out, 1: quadrature channel A. Reset 0.
- `b`, out, 1: quadrature channel B. Reset 0.
- `idx`, out, 1: high while position == 0. Reset 1.
- `cmd_valid`, out, 1: one-cycle pulse when a new command is committed. Reset 0.

## Operation
Serial input:
- `scl` and `sdi` each pass through a 2-flop synchronizer.
- A rising edge on synchronized `scl` shifts synchronized `sdi` into a 12-bit register, MSB first, and increments a 4-bit bit counter.
- The frame is complete on the 12th edge:
  - bit 11 = `dir` (1 = forward),
  - bit 10 = `en`,
  - bits 9:0 = `code`.
- On completion, the block loads the active command registers, clears the bit counter and pulses `cmd_valid`.
- A partial frame with no `scl` edge for `TIMEOUT` consecutive cycles clears the bit counter. Active registers are unchanged.

Rate generation:
- The prescaler counts 0..`PRESCALE-1` and emits a tick on wrap.
- The step counter counts ticks 0..`code`. On wrap it issues a step.
- Step interval = (`code`+1)·`PRESCALE` cycles.
- Both counters run only while `en`=1. While `en`=0 they are held at 0 and no steps occur.

Position and outputs:
- `pos` is a counter modulo `COUNTS_PER_REV`.
- A step increments `pos` if `dir`=1 and decrements it if `dir`=0. It wraps both ways: max→0 and 0→max.
- {a,b} are registered from `pos[1:0]`: 0→00, 1→10, 2→11, 3→01.
  - Forward means A leads B, so A rises while B is low.
  - Exactly one of a/b toggles per step.
- `idx` = (`pos` == 0), registered.
- Direction reversal continues from the current `pos`, with no reset of the phase. No output glitch is allowed.

## Timing
- `scl` edge to shift: 3 cycles (2 sync flops plus the edge-detect register).
- `cmd_valid` is asserted the cycle after the 12th edge is detected. The active command takes effect in that same cycle.
- Commit clears the prescaler and step counter. The first step under the new command lands (`code`+1)·`PRESCALE` cycles after `cmd_valid`.
- Step to output: a, b and idx change on the cycle after the step strobe.
- Commit and step strobe in the same cycle: the commit wins and the step is suppressed.
- `code`=0 steps every `PRESCALE` cycles. `code`=1023 steps every 1024·`PRESCALE` cycles.
- Assertion of `reset` at any point, including mid-frame or mid-interval, clears everything:
  - shift register, bit counter and timeout counter;
  - active command to `dir`=0, `en`=0, `code`=0;
  - both counters and `pos`;
  - outputs to a=0, b=0, idx=1, cmd_valid=0.

  Release is synchronized internally to `clock`.

## Structure
- Shared package `motor_pkg` holds:
  - frame width and field positions (`FRAME_W`=12, `DIR_BIT`=11, `EN_BIT`=10, `CODE_W`=10);
  - the quadrature state encoding constants.
- Sub-module `serial_frame_rx` holds the synchronizers, edge detect, shift register, bit counter and timeout. It outputs the frame and a done strobe.
- The top level holds the rate generator, position counter and output registers.

## Test plan
- Reset, then frame {dir=1, en=1, code=4} with `PRESCALE`=10 → `cmd_valid` pulses once; a,b step 00→10→11→01→00 with 50 cycles per step.
- Forward steps across `pos`=`COUNTS_PER_REV`-1 → `pos` wraps to 0; `idx` rises for exactly one step interval; a,b=00.
- Running forward, send dir=0 mid-sequence at {a,b}=11 → next state is 10; only one channel toggles per step; no glitch.
- Send 7 bits, idle `TIMEOUT` cycles, then a full frame with en=0 → the partial frame is discarded; outputs freeze; no `cmd_valid` for the partial frame.
- Commit timed on a step boundary → no step that cycle; the next step comes 50 cycles after `cmd_valid`.
- Assert `reset` mid-frame while stepping → a=b=0, idx=1 immediately; the first post-reset frame decodes correctly.
